// File: rtl/byte_encode_stream.sv
// Sequential ByteEncode_ELL: packs NUM_COEFFS ELL-bit coefficients into a little-endian
// byte stream through a small shift buffer, with valid/ready handshakes on both sides.
module byte_encode_stream #(
  parameter int unsigned ELL        = 12,
  parameter int unsigned NUM_COEFFS = 256,
  parameter int unsigned BYTE_COUNT = 32 * ELL,
  parameter int unsigned Q          = 3329
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_coeff_valid,
  output logic           o_coeff_ready,
  input  logic [ELL-1:0] i_coeff_data,
  output logic           o_byte_valid,
  input  logic           i_byte_ready,
  output logic [7:0]     o_byte_data,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err
);

  localparam int unsigned BufW  = ELL + 7;
  localparam int unsigned BcntW = $clog2(ELL + 8);
  localparam int unsigned CcntW = $clog2(NUM_COEFFS) + 1;
  localparam int unsigned OcntW = $clog2(BYTE_COUNT) + 1;

  typedef enum logic [1:0] {StIdle, StPack, StDone} state_e;

  state_e            r_state;
  logic [BufW-1:0]   r_buf;
  logic [BcntW-1:0]  r_bcnt;
  logic [CcntW-1:0]  r_ccnt;
  logic [OcntW-1:0]  r_ocnt;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [BufW-1:0]   w_ext;
  logic [BufW-1:0]   w_shifted;
  logic              w_accept;
  logic              w_emit;
  logic              w_range_bad;
  logic              w_last_byte;

  // Ready only while fewer than 8 bits are buffered, valid only once 8 are: never both at once.
  assign o_coeff_ready = (r_state == StPack) && (r_bcnt < BcntW'(8)) &&
                         (r_ccnt < CcntW'(NUM_COEFFS));
  assign o_byte_valid  = (r_state == StPack) && (r_bcnt >= BcntW'(8));
  assign o_byte_data   = r_buf[7:0];
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;

  assign w_accept    = o_coeff_ready && i_coeff_valid;
  assign w_emit      = o_byte_valid && i_byte_ready;
  assign w_ext       = BufW'(i_coeff_data);
  assign w_shifted   = w_ext << r_bcnt;
  assign w_range_bad = (ELL == 12) && (32'(i_coeff_data) >= Q);
  assign w_last_byte = (r_ocnt == OcntW'(BYTE_COUNT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_buf   <= '0;
      r_bcnt  <= '0;
      r_ccnt  <= '0;
      r_ocnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= StPack;
            r_buf   <= '0;
            r_bcnt  <= '0;
            r_ccnt  <= '0;
            r_ocnt  <= '0;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        StPack: begin
          if (w_accept) begin
            r_buf  <= r_buf | w_shifted;
            r_bcnt <= r_bcnt + BcntW'(ELL);
            r_ccnt <= r_ccnt + CcntW'(1);
            if (w_range_bad) begin
              r_err <= 1'b1;
            end
          end else if (w_emit) begin
            r_buf  <= r_buf >> 8;
            r_bcnt <= r_bcnt - BcntW'(8);
            r_ocnt <= r_ocnt + OcntW'(1);
            if (w_last_byte) begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_encode_stream.sv
// Bench for byte_encode_stream: ELL=12 and ELL=1 instances, table vectors plus randomized
// handshakes checked against a bit-level stream model and a decode round trip.
module tb_byte_encode_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic        coeff_valid = 1'b0;
  logic [11:0] coeff_data = '0;
  logic        byte_ready = 1'b0;

  logic        cr12, bv12, busy12, done12, err12;
  logic [7:0]  bd12;
  logic        cr1, bv1, busy1, done1, err1;
  logic [7:0]  bd1;
  logic        start12, start1;
  logic [0:0]  coeff_data1;

  logic        w_cr, w_bv, w_busy, w_done, w_err;
  logic [7:0]  w_bd;

  int checks = 0;
  int errors = 0;

  int unsigned coeffs[256];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int          spacing_bad;

  typedef struct {
    int         test;
    int         idx;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  assign start12     = start & ~sel;
  assign start1      = start & sel;
  assign coeff_data1 = coeff_data[0];

  assign w_cr   = sel ? cr1   : cr12;
  assign w_bv   = sel ? bv1   : bv12;
  assign w_bd   = sel ? bd1   : bd12;
  assign w_busy = sel ? busy1 : busy12;
  assign w_done = sel ? done1 : done12;
  assign w_err  = sel ? err1  : err12;

  byte_encode_stream #(.ELL(12)) u_dut12 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start12),
    .i_coeff_valid(coeff_valid),
    .o_coeff_ready(cr12),
    .i_coeff_data (coeff_data),
    .o_byte_valid (bv12),
    .i_byte_ready (byte_ready),
    .o_byte_data  (bd12),
    .o_busy       (busy12),
    .o_done       (done12),
    .o_err        (err12)
  );

  byte_encode_stream #(.ELL(1), .BYTE_COUNT(32)) u_dut1 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start1),
    .i_coeff_valid(coeff_valid),
    .o_coeff_ready(cr1),
    .i_coeff_data (coeff_data1),
    .o_byte_valid (bv1),
    .i_byte_ready (byte_ready),
    .o_byte_data  (bd1),
    .o_busy       (busy1),
    .o_done       (done1),
    .o_err        (err1)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: stream bit s comes from bit (s % ell) of coefficient (s / ell).
  task automatic build_model(input int ell);
    exp_q.delete();
    for (int b = 0; b < 32 * ell; b++) begin
      logic [7:0] v;
      v = '0;
      for (int k = 0; k < 8; k++) begin
        int s;
        s = 8 * b + k;
        v[k] = 1'((coeffs[s / ell] >> (s % ell)) & 1);
      end
      exp_q.push_back(v);
    end
  endtask

  task automatic compare_stream(input string name);
    int bad, first;
    bad = 0;
    first = -1;
    if (got_q.size() != exp_q.size()) bad++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0)
      $display("  first byte difference at %0d: %0h vs %0h", first, got_q[first], exp_q[first]);
    chk(name, bad, 0);
  endtask

  task automatic check_table(input int test);
    foreach (tbl[i]) begin
      if (tbl[i].test == test) begin
        if (tbl[i].idx < got_q.size())
          chk($sformatf("t%0d_byte%0d", test, tbl[i].idx), int'(got_q[tbl[i].idx]),
              int'(tbl[i].exp));
        else
          chk($sformatf("t%0d_byte%0d_missing", test, tbl[i].idx), got_q.size(), tbl[i].idx + 1);
      end
    end
  endtask

  task automatic run_poly(input int ell, input int rdy_pct, input int vld_pct,
                          input int abort_at, input bit poke_start);
    int ci, bc, cyc, acc_since, nbytes;
    logic       stall_prev;
    logic [7:0] stall_data;
    nbytes = 32 * ell;
    got_q.delete();
    spacing_bad = 0;
    sel = (ell == 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_after_start", w_busy, 1);
    chk("err_clear_on_start", w_err, 0);
    ci = 0; bc = 0; cyc = 0; acc_since = 0; stall_prev = 1'b0; stall_data = '0;
    while (bc < nbytes && !(abort_at > 0 && bc >= abort_at) && cyc < 8000) begin
      coeff_valid = (ci < 256) && ($urandom_range(99) < vld_pct);
      coeff_data  = (ci < 256) ? 12'(coeffs[ci]) : 12'(0);
      byte_ready  = ($urandom_range(99) < rdy_pct);
      start       = poke_start && (cyc == 5);
      #1;
      if (stall_prev) chk("stall_stable", {w_bv, w_bd}, {1'b1, stall_data});
      if (w_cr && coeff_valid) begin
        ci++;
        acc_since++;
      end
      if (w_bv && byte_ready) begin
        got_q.push_back(w_bd);
        if (ell == 1 && acc_since != 8) spacing_bad++;
        acc_since = 0;
        bc++;
      end
      stall_prev = w_bv && !byte_ready;
      stall_data = w_bd;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    coeff_valid = 1'b0;
    byte_ready = 1'b0;
    if (abort_at > 0) begin
      rst = 1'b1;
      #1;
      chk("abort_outputs_zero", {cr12, bv12, bd12, busy12, done12, err12}, 0);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      chk("byte_count", bc, nbytes);
      #1;
      chk("done_pulse", {w_done, w_busy}, 2'b10);
      @(negedge clk);
      #1;
      chk("done_once", {w_done, w_busy}, 2'b00);
    end
  endtask

  initial begin
    tbl.push_back('{1, 0, 8'h49});
    tbl.push_back('{1, 1, 8'h8B});
    tbl.push_back('{1, 2, 8'h0B});
    tbl.push_back('{1, 3, 8'hFF});
    tbl.push_back('{1, 4, 8'hFE});
    tbl.push_back('{1, 5, 8'hCE});
    tbl.push_back('{1, 6, 8'h00});
    tbl.push_back('{1, 383, 8'h00});
    tbl.push_back('{3, 0, 8'h55});
    tbl.push_back('{3, 31, 8'h55});
    tbl.push_back('{4, 6, 8'h00});
    tbl.push_back('{4, 7, 8'h10});
    tbl.push_back('{4, 8, 8'hD0});
    tbl.push_back('{4, 9, 8'h00});

    #3;
    chk("reset_outputs12", {cr12, bv12, bd12, busy12, done12, err12}, 0);
    chk("reset_outputs1", {cr1, bv1, bd1, busy1, done1, err1}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    coeff_valid = 1'b1;
    #1;
    chk("idle_no_ready", {cr12, cr1, bv12, bv1}, 0);
    coeff_valid = 1'b0;

    // Known vector, full-rate handshakes.
    foreach (coeffs[i]) coeffs[i] = 0;
    coeffs[0] = 2889; coeffs[1] = 184; coeffs[2] = 3839; coeffs[3] = 3311;
    run_poly(12, 100, 100, 0, 1'b0);
    build_model(12);
    compare_stream("t1_stream");
    check_table(1);
    chk("t1_err_3839", w_err, 1);

    // Same vector with random stalls on both sides.
    run_poly(12, 50, 70, 0, 1'b0);
    compare_stream("t2_stream");
    check_table(1);

    // ELL=1 alternating bits.
    foreach (coeffs[i]) coeffs[i] = (i % 2 == 0) ? 1 : 0;
    run_poly(1, 100, 100, 0, 1'b0);
    build_model(1);
    compare_stream("t3_stream");
    check_table(3);
    chk("t3_accept_spacing", spacing_bad, 0);

    // Coefficient equal to Q is flagged but still packed.
    foreach (coeffs[i]) coeffs[i] = 0;
    coeffs[5] = 3329;
    run_poly(12, 100, 100, 0, 1'b0);
    check_table(4);
    chk("t4_err_set", w_err, 1);
    repeat (3) @(negedge clk);
    chk("t4_err_held", w_err, 1);

    // Abort after byte 10 with a stray start during PACK.
    foreach (coeffs[i]) coeffs[i] = $urandom_range(3328);
    run_poly(12, 80, 80, 10, 1'b1);

    // Fresh polynomial after the abort, random coefficients, random handshakes.
    foreach (coeffs[i]) coeffs[i] = $urandom_range(3328);
    run_poly(12, 60, 60, 0, 1'b1);
    build_model(12);
    compare_stream("t6_stream");
    chk("t6_err_clean", w_err, 0);
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        int c;
        c = 0;
        for (int j = 0; j < 12; j++) begin
          int s;
          s = i * 12 + j;
          if (s / 8 < got_q.size()) c += ((int'(got_q[s / 8]) >> (s % 8)) & 1) << j;
        end
        if (c != int'(coeffs[i])) bad++;
      end
      chk("t6_round_trip", bad, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
